// File: rtl/wb_stage.sv
// Write-back stage: registers the completed MEM-stage uop, aligns and extends load data,
// and drives the GPR/CSR write ports plus the retired-instruction counter.
module wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      mem_valid_i,
    input  logic [DATA_WIDTH-1:0]     exe_out_i,
    input  logic [DATA_WIDTH-1:0]     op3_i,
    input  logic [4:0]                rd_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [1:0]                gpr_ctrl_i,
    input  logic                      csr_ctrl_i,
    input  logic [3:0]                mem_ctrl_i,
    input  logic [DATA_WIDTH-1:0]     d_m_rdata_i,
    output logic                      gpr_wren_o,
    output logic [4:0]                gpr_waddr_o,
    output logic [DATA_WIDTH-1:0]     gpr_wdata_o,
    output logic                      csr_wren_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic [4:0]                wb2ctrl_rd_o,
    output logic [63:0]               instret_o
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] GPR_IDLE = 2'b00;
    localparam logic [1:0] GPR_EXE  = 2'b01;
    localparam logic [1:0] GPR_MEM  = 2'b10;
    localparam logic [1:0] GPR_OP3  = 2'b11;

    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     exe_out_q;
    logic [DATA_WIDTH-1:0]     op3_q;
    logic [4:0]                rd_q;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
    logic [1:0]                gpr_ctrl_q;
    logic                      csr_ctrl_q;
    logic [3:0]                mem_ctrl_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [63:0]               instret_q;

    // Shift the read word down by the byte offset, then truncate and extend.
    // Misaligned offsets simply yield the shifted bytes; no fault is raised here.
    function automatic logic [DATA_WIDTH-1:0] load_align(
        input logic [DATA_WIDTH-1:0] data,
        input logic [OFF_W-1:0]      offset,
        input logic [3:0]            ctrl
    );
        logic [DATA_WIDTH-1:0] shifted;
        logic                  is_unsigned;
        shifted     = data >> {offset, 3'b000};
        is_unsigned = ctrl[2];
        case (ctrl[1:0])
            2'b00:   load_align = is_unsigned ? DATA_WIDTH'(shifted[7:0])
                                              : DATA_WIDTH'($signed(shifted[7:0]));
            2'b01:   load_align = is_unsigned ? DATA_WIDTH'(shifted[15:0])
                                              : DATA_WIDTH'($signed(shifted[15:0]));
            2'b10:   load_align = is_unsigned ? DATA_WIDTH'(shifted[31:0])
                                              : DATA_WIDTH'($signed(shifted[31:0]));
            // dword is the full register; on a 32-bit core this is identical to word
            default: load_align = shifted;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q     <= 1'b0;
            exe_out_q   <= '0;
            op3_q       <= '0;
            rd_q        <= '0;
            csr_waddr_q <= '0;
            gpr_ctrl_q  <= GPR_IDLE;
            csr_ctrl_q  <= 1'b0;
            mem_ctrl_q  <= '0;
            rdata_q     <= '0;
            instret_q   <= '0;
        end else begin
            if (valid_q) begin
                instret_q <= instret_q + 64'd1;
            end
            if (mem_valid_i) begin
                valid_q     <= 1'b1;
                exe_out_q   <= exe_out_i;
                op3_q       <= op3_i;
                rd_q        <= rd_i;
                csr_waddr_q <= csr_waddr_i;
                gpr_ctrl_q  <= gpr_ctrl_i;
                csr_ctrl_q  <= csr_ctrl_i;
                mem_ctrl_q  <= mem_ctrl_i;
                rdata_q     <= d_m_rdata_i;
            end else begin
                // Bubble: only the control fields are cleared, data holds.
                valid_q    <= 1'b0;
                gpr_ctrl_q <= GPR_IDLE;
                csr_ctrl_q <= 1'b0;
                rd_q       <= '0;
            end
        end
    end

    always_comb begin
        gpr_wdata_o = '0;
        case (gpr_ctrl_q)
            GPR_EXE: gpr_wdata_o = exe_out_q;
            GPR_MEM: gpr_wdata_o = load_align(rdata_q, exe_out_q[OFF_W-1:0], mem_ctrl_q);
            GPR_OP3: gpr_wdata_o = op3_q;
            default: gpr_wdata_o = '0;
        endcase
    end

    assign gpr_wren_o   = valid_q && (gpr_ctrl_q != GPR_IDLE) && (rd_q != 5'd0);
    assign gpr_waddr_o  = rd_q;
    assign csr_wren_o   = valid_q && csr_ctrl_q;
    assign csr_waddr_o  = csr_waddr_q;
    assign csr_wdata_o  = exe_out_q;
    assign wb2ctrl_rd_o = rd_q;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (DATA_WIDTH=32): vector table of single uops plus
// hand-written sequences for back-to-back retirement and asynchronous reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_valid;
    logic [31:0] exe_out;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic [11:0] csr_waddr;
    logic [1:0]  gpr_ctrl;
    logic        csr_ctrl;
    logic [3:0]  mem_ctrl;
    logic [31:0] rdata;
    logic        gpr_wren;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wren;
    logic [11:0] csr_waddr_out;
    logic [31:0] csr_wdata;
    logic [4:0]  wb_rd;
    logic [63:0] instret;

    int tests = 0;
    int fails = 0;

    wb_stage #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .mem_valid_i  (mem_valid),
        .exe_out_i    (exe_out),
        .op3_i        (op3),
        .rd_i         (rd),
        .csr_waddr_i  (csr_waddr),
        .gpr_ctrl_i   (gpr_ctrl),
        .csr_ctrl_i   (csr_ctrl),
        .mem_ctrl_i   (mem_ctrl),
        .d_m_rdata_i  (rdata),
        .gpr_wren_o   (gpr_wren),
        .gpr_waddr_o  (gpr_waddr),
        .gpr_wdata_o  (gpr_wdata),
        .csr_wren_o   (csr_wren),
        .csr_waddr_o  (csr_waddr_out),
        .csr_wdata_o  (csr_wdata),
        .wb2ctrl_rd_o (wb_rd),
        .instret_o    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exe;
        logic [31:0] op3;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [11:0] csr_a;
        logic [1:0]  gpr;
        logic        csr;
        logic [3:0]  mem;
        logic        exp_wren;
        logic [31:0] exp_wdata;
        logic        exp_cwren;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_valid = 1'b1;
        exe_out   = v.exe;
        op3       = v.op3;
        rdata     = v.rdata;
        rd        = v.rd;
        csr_waddr = v.csr_a;
        gpr_ctrl  = v.gpr;
        csr_ctrl  = v.csr;
        mem_ctrl  = v.mem;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " gpr_wren"},  64'(gpr_wren), 64'd0);
        check({tag, " gpr_waddr"}, 64'(gpr_waddr), 64'd0);
        check({tag, " gpr_wdata"}, 64'(gpr_wdata), 64'd0);
        check({tag, " csr_wren"},  64'(csr_wren), 64'd0);
        check({tag, " csr_waddr"}, 64'(csr_waddr_out), 64'd0);
        check({tag, " csr_wdata"}, 64'(csr_wdata), 64'd0);
        check({tag, " wb_rd"},     64'(wb_rd), 64'd0);
        check({tag, " instret"},   instret, 64'd0);
    endtask

    initial begin
        //            exe           op3           rdata         rd     csr_a    gpr    csr   mem      wren  wdata         cwren
        vecs[0]  = '{32'h0000_1003, 32'h0,        32'h80FF_0000, 5'd5,  12'h000, 2'b10, 1'b0, 4'b1000, 1'b1, 32'hFFFF_FF80, 1'b0}; // LB
        vecs[1]  = '{32'h0000_2002, 32'h0,        32'h8001_1234, 5'd6,  12'h000, 2'b10, 1'b0, 4'b1101, 1'b1, 32'h0000_8001, 1'b0}; // LHU
        vecs[2]  = '{32'h0000_2002, 32'h0,        32'h8001_1234, 5'd6,  12'h000, 2'b10, 1'b0, 4'b1001, 1'b1, 32'hFFFF_8001, 1'b0}; // LH
        vecs[3]  = '{32'h0000_0008, 32'h1800,     32'h0,         5'd7,  12'h300, 2'b11, 1'b1, 4'b0000, 1'b1, 32'h0000_1800, 1'b1}; // CSR
        vecs[4]  = '{32'h0000_0055, 32'h0,        32'h0,         5'd0,  12'h000, 2'b01, 1'b0, 4'b0000, 1'b0, 32'h0000_0055, 1'b0}; // x0
        vecs[5]  = '{32'hDEAD_BEEF, 32'h0,        32'h0,         5'd31, 12'h000, 2'b01, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0}; // ALU
        vecs[6]  = '{32'h0000_4000, 32'h0,        32'h1234_5678, 5'd8,  12'h000, 2'b10, 1'b0, 4'b1010, 1'b1, 32'h1234_5678, 1'b0}; // LW
        vecs[7]  = '{32'h0000_4001, 32'h0,        32'h0000_A500, 5'd9,  12'h000, 2'b10, 1'b0, 4'b1100, 1'b1, 32'h0000_00A5, 1'b0}; // LBU
        vecs[8]  = '{32'h0000_4000, 32'h0,        32'hCAFE_F00D, 5'd10, 12'h000, 2'b10, 1'b0, 4'b1011, 1'b1, 32'hCAFE_F00D, 1'b0}; // size 11
        vecs[9]  = '{32'h0000_0077, 32'h99,       32'h0,         5'd3,  12'h000, 2'b00, 1'b0, 4'b0000, 1'b0, 32'h0000_0000, 1'b0}; // idle ctrl
        vecs[10] = '{32'h0000_4001, 32'h0,        32'h1122_3344, 5'd11, 12'h000, 2'b10, 1'b0, 4'b1010, 1'b1, 32'h0011_2233, 1'b0}; // misaligned LW
        vecs[11] = '{32'h0000_4003, 32'h0,        32'h8012_3456, 5'd12, 12'h7C0, 2'b10, 1'b1, 4'b1001, 1'b1, 32'h0000_0080, 1'b1}; // misaligned LH + CSR

        rstn = 1'b0;
        mem_valid = 1'b0; exe_out = '0; op3 = '0; rdata = '0; rd = '0;
        csr_waddr = '0; gpr_ctrl = '0; csr_ctrl = 1'b0; mem_ctrl = '0;

        // Reset dominates even with a valid uop offered on a clock edge.
        #1;
        check_zero("reset");
        drive(vecs[0]);
        @(posedge clk); #1;
        check_zero("reset_edge");

        @(negedge clk);
        rstn = 1'b1;
        mem_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("v%0d gpr_wren", i),  64'(gpr_wren), 64'(vecs[i].exp_wren));
            check($sformatf("v%0d gpr_waddr", i), 64'(gpr_waddr), 64'(vecs[i].rd));
            check($sformatf("v%0d gpr_wdata", i), 64'(gpr_wdata), 64'(vecs[i].exp_wdata));
            check($sformatf("v%0d csr_wren", i),  64'(csr_wren), 64'(vecs[i].exp_cwren));
            check($sformatf("v%0d csr_waddr", i), 64'(csr_waddr_out), 64'(vecs[i].csr_a));
            check($sformatf("v%0d csr_wdata", i), 64'(csr_wdata), 64'(vecs[i].exe));
            check($sformatf("v%0d wb_rd", i),     64'(wb_rd), 64'(vecs[i].rd));
            check($sformatf("v%0d instret", i),   instret, 64'(i));
        end

        // Bubble: controls clear, data fields such as the CSR address hold.
        @(negedge clk);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("idle gpr_wren",  64'(gpr_wren), 64'd0);
        check("idle csr_wren",  64'(csr_wren), 64'd0);
        check("idle wb_rd",     64'(wb_rd), 64'd0);
        check("idle gpr_wdata", 64'(gpr_wdata), 64'd0);
        check("idle csr_waddr", 64'(csr_waddr_out), 64'h7C0);
        check("idle csr_wdata", 64'(csr_wdata), 64'h4003);
        check("idle instret",   instret, 64'd12);
        @(posedge clk); #1;
        check("idle2 instret",  instret, 64'd12);

        // Ten back-to-back uops after a fresh reset.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst2 instret", instret, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_valid = 1'b1; gpr_ctrl = 2'b01; csr_ctrl = 1'b0; mem_ctrl = '0;
            rd = 5'(i + 1); exe_out = 32'(i * 16 + 3);
            @(posedge clk); #1;
            check($sformatf("b2b%0d gpr_wren", i),  64'(gpr_wren), 64'd1);
            check($sformatf("b2b%0d gpr_waddr", i), 64'(gpr_waddr), 64'(i + 1));
            check($sformatf("b2b%0d gpr_wdata", i), 64'(gpr_wdata), 64'(i * 16 + 3));
            check($sformatf("b2b%0d instret", i),   instret, 64'(i));
        end
        @(negedge clk);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_end instret",  instret, 64'd10);
        check("b2b_end wb_rd",    64'(wb_rd), 64'd0);
        check("b2b_end gpr_wren", 64'(gpr_wren), 64'd0);

        // Reset between edges while a uop is held.
        @(negedge clk);
        mem_valid = 1'b1; gpr_ctrl = 2'b01; rd = 5'd4; exe_out = 32'h1234;
        @(posedge clk); #1;
        check("hold gpr_wren", 64'(gpr_wren), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_rst");

        // First capture happens on the first rising edge after release.
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst gpr_wren",  64'(gpr_wren), 64'd1);
        check("post_rst gpr_waddr", 64'(gpr_waddr), 64'd4);
        check("post_rst instret",   instret, 64'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst2 instret",  instret, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, GPR/CSR/memory data width; legal values are 32 and 64.
REQ-002 Parameter CSR_ADDR_WIDTH, default 12, CSR address width.
REQ-003 clk_i  input  1  system clock; the block has one clock only.
REQ-004 rstn_i  input  1  asynchronous, active-low reset.
REQ-005 mem_valid_i  input  1  MEM stage has completed the uop; payload and rdata are valid this cycle.
REQ-006 exe_out_i  input  DATA_WIDTH  EXE result; for loads and stores, the byte address.
REQ-007 op3_i  input  DATA_WIDTH  secondary operand (old CSR value for CSR instructions).
REQ-008 rd_i  input  5  destination GPR index.
REQ-009 csr_waddr_i  input  CSR_ADDR_WIDTH  destination CSR address.
REQ-010 gpr_ctrl_i  input  2  GPR source select: 00 IDLE, 01 EXE_OUT, 10 MEM_DATA, 11 OP3.
REQ-011 csr_ctrl_i  input  1  when 1, write exe_out to the CSR.
REQ-012 mem_ctrl_i  input  4  [3] load, [2] unsigned, [1:0] size (00 byte, 01 half, 10 word, 11 dword).
REQ-013 d_m_rdata_i  input  DATA_WIDTH  data-memory read data, sampled with mem_valid_i.
REQ-014 gpr_wren_o  output  1  GPR write enable.
REQ-015 gpr_waddr_o  output  5  GPR write index.
REQ-016 gpr_wdata_o  output  DATA_WIDTH  GPR write data.
REQ-017 csr_wren_o  output  1  CSR write enable.
REQ-018 csr_waddr_o  output  CSR_ADDR_WIDTH  CSR write address.
REQ-019 csr_wdata_o  output  DATA_WIDTH  CSR write data.
REQ-020 wb2ctrl_rd_o  output  5  rd of the uop held in WB, for hazard detection; 0 when no uop is held.
REQ-021 instret_o  output  64  retired-instruction counter.

Function
REQ-022 The input register SHALL capture the full payload and d_m_rdata_i on any clock edge where mem_valid_i=1, and set valid_q=1.
REQ-023 If mem_valid_i=0 on an edge, the block SHALL clear valid_q, gpr_ctrl_q and csr_ctrl_q, and set rd_q=0; the other fields SHALL hold their values.
REQ-024 Latency SHALL be exactly one cycle from mem_valid_i to the write-enable outputs; write outputs SHALL be combinational from the registered state only.
REQ-025 gpr_wren_o SHALL equal valid_q AND (gpr_ctrl_q!=00) AND (rd_q!=0); writes to x0 are suppressed.
REQ-026 gpr_wdata_o SHALL be exe_out_q for 01, load-aligned data for 10, op3_q for 11, and 0 for 00.
REQ-027 Load alignment: byte offset = exe_out_q[log2(DATA_WIDTH/8)-1:0]; rdata_q SHALL be right-shifted by offset*8, then truncated to the size.
REQ-028 After truncation, the result SHALL be sign-extended when mem_ctrl_q[2]=0 and zero-extended when it is 1.
REQ-029 When DATA_WIDTH=32, size 11 SHALL be treated as word.
REQ-030 A misaligned offset SHALL produce the shifted data without fault; alignment checking is the responsibility of upstream stages.
REQ-031 csr_wren_o SHALL equal valid_q AND csr_ctrl_q, with csr_waddr_o=csr_waddr_q and csr_wdata_o=exe_out_q.
REQ-032 GPR and CSR writes of the same uop SHALL assert in the same cycle.
REQ-033 instret_o SHALL increment by 1 on every edge where valid_q=1, regardless of the write enables.
REQ-034 instret_o SHALL wrap from 2^64-1 to 0.
REQ-035 Back-to-back mem_valid_i SHALL retire one uop per cycle with no bubble.

Reset
REQ-036 While rstn_i=0, all registers and all outputs SHALL be 0, asynchronously and independent of clk_i.
REQ-037 Reset asserted mid-operation SHALL discard the held uop and suppress its write in that cycle.
REQ-038 The first capture after reset SHALL occur on the first rising edge with rstn_i=1 and mem_valid_i=1.

Verification
REQ-039 LB: exe_out=0x1003, rdata=0x80FF_0000, mem_ctrl=1000, gpr_ctrl=10, rd=5 -> next cycle gpr_wren=1, waddr=5, wdata=0xFFFF_FF80.
REQ-040 LHU: offset 2, rdata=0x8001_1234, mem_ctrl=1101 -> wdata=0x0000_8001; with mem_ctrl=1001 (LH) -> wdata=0xFFFF_8001.
REQ-041 CSR op: csr_ctrl=1, csr_waddr=0x300, exe_out=0x8, op3=0x1800, gpr_ctrl=11, rd=7 -> csr_wren=1, csr_wdata=0x8, gpr_wdata=0x1800, both in the same cycle.
REQ-042 rd=0 with gpr_ctrl=01 -> gpr_wren=0, instret still increments.
REQ-043 Ten back-to-back valids then one idle cycle -> ten consecutive write cycles, instret=10, then wb2ctrl_rd_o=0.
REQ-044 Reset asserted between clock edges while valid_q=1 -> gpr_wren_o drops immediately and instret_o reads 0.
